// File: rtl/sms32_gf_pkg.sv
// Shared definitions for the power-S-box inverter.
//   Byte representation : GF(2^6), polynomial basis, p(x) = x^6+x^5+x^3+x^2+1
//   Compute field       : GF((2^3)^2) = GF(8)[z]/(z^2+z+1), GF(8) = GF(2)[t]/(t^3+t+1)
//   Composite element   : {a1[2:0], a0[2:0]} meaning a1*z + a0
// The iso map sends x^i to beta^i, where beta = z + t is a root of p(x).
package sms32_gf_pkg;

    localparam int          EXP_W    = 6;
    localparam logic [5:0]  EXP_INV  = 6'd41;   // 20^-1 mod 63
    localparam logic [5:0]  EXP_FWD  = 6'd20;
    localparam logic [5:0]  COMP_ONE = 6'b000001;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXP  = 2'd1,
        DONE = 2'd2
    } state_t;

    // GF(8) multiply, reduced with t^3 = t+1 and t^4 = t^2+t
    function automatic logic [2:0] gf8_mul(input logic [2:0] a, input logic [2:0] b);
        logic [4:0] p;
        p = '0;
        for (int i = 0; i < 3; i++) begin
            if (b[i]) p = p ^ ({2'b00, a} << i);
        end
        return p[2:0] ^ (p[3] ? 3'b011 : 3'b000) ^ (p[4] ? 3'b110 : 3'b000);
    endfunction

    // GF(8) square: a2*t^4 + a1*t^2 + a0 with t^4 = t^2+t
    function automatic logic [2:0] gf8_sq(input logic [2:0] a);
        return {a[2] ^ a[1], a[2], a[0]};
    endfunction

    // Polynomial basis -> composite basis (columns are beta^0..beta^5)
    function automatic logic [5:0] iso(input logic [5:0] x);
        logic [5:0] o;
        o[0] = x[0] ^ x[2];
        o[1] = x[1] ^ x[4] ^ x[5];
        o[2] = x[2] ^ x[4] ^ x[5];
        o[3] = x[1] ^ x[2] ^ x[4] ^ x[5];
        o[4] = x[3];
        o[5] = x[3] ^ x[5];
        return o;
    endfunction

    // Composite basis -> polynomial basis (inverse of iso)
    function automatic logic [5:0] inv_iso(input logic [5:0] o);
        logic [5:0] x;
        x[0] = o[0] ^ o[1] ^ o[3];
        x[1] = o[2] ^ o[3];
        x[2] = o[1] ^ o[3];
        x[3] = o[4];
        x[4] = o[1] ^ o[2] ^ o[3] ^ o[4] ^ o[5];
        x[5] = o[4] ^ o[5];
        return x;
    endfunction

endpackage

// File: rtl/gf64_comp_mul.sv
// Combinational GF((2^3)^2) multiplier, z^2 = z + 1:
//   (a1 z + a0)(b1 z + b0) = (a1b1 + a1b0 + a0b1) z + (a1b1 + a0b0)
module gf64_comp_mul
    import sms32_gf_pkg::*;
(
    input  logic [5:0] a,
    input  logic [5:0] b,
    output logic [5:0] p
);

    // Four GF(8) partial products: index gi selects {a half, b half}
    logic [2:0] pp [4];

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_pp
            localparam int AH = (gi >> 1) & 1;
            localparam int BH = gi & 1;
            assign pp[gi] = gf8_mul(a[AH*3 +: 3], b[BH*3 +: 3]);
        end
    endgenerate

    // pp[3]=a1b1, pp[2]=a1b0, pp[1]=a0b1, pp[0]=a0b0
    assign p = {pp[3] ^ pp[2] ^ pp[1], pp[3] ^ pp[0]};

endmodule

// File: rtl/sms32_20_inv_iter.sv
// Iterative inverse of the power-20 S-box: y = x^41 over GF(2^6),
// computed by MSB-first square-and-multiply in the composite field.
// Fixed latency: accept in cycle T, out_valid first high in T+7.
// Optional macro SMS32_FWD_MODE_EN adds a 'mode' port (1 = forward x^20).
module sms32_20_inv_iter
    import sms32_gf_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [EXP_W-1:0] x,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [EXP_W-1:0] y
`ifdef SMS32_FWD_MODE_EN
    ,
    input  logic             mode
`endif
);

    state_t           state_reg, state_next;
    logic [5:0]       w_reg;
    logic [5:0]       acc_reg;
    logic [2:0]       step_reg;
    logic [5:0]       y_reg;
    logic [5:0]       exp_sel;
    logic [7:0]       exp_ext;
    logic [5:0]       acc_sq;
    logic [5:0]       acc_mw;
    logic [5:0]       acc_step;
    logic             accept;

`ifdef SMS32_FWD_MODE_EN
    logic             mode_reg;

    // Exponent choice is latched with the operand
    always_ff @(posedge clk) begin
        if (rst) begin
            mode_reg <= 1'b0;
        end else if (accept) begin
            mode_reg <= mode;
        end
    end

    assign exp_sel = mode_reg ? EXP_FWD : EXP_INV;
`else
    assign exp_sel = EXP_INV;
`endif

    // Widened so the 3-bit step counter indexes without a range issue
    assign exp_ext = {2'b00, exp_sel};

    gf64_comp_mul u_square (
        .a (acc_reg),
        .b (acc_reg),
        .p (acc_sq)
    );

    gf64_comp_mul u_multiply (
        .a (acc_sq),
        .b (w_reg),
        .p (acc_mw)
    );

    assign acc_step = exp_ext[step_reg] ? acc_mw : acc_sq;
    assign accept   = in_valid && in_ready;
    assign y        = y_reg;

    // Next state and handshake outputs
    always_comb begin
        state_next = state_reg;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        case (state_reg)
            IDLE: begin
                in_ready = 1'b1;
                if (accept) state_next = EXP;
            end
            EXP: begin
                if (step_reg == 3'd0) state_next = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                in_ready  = out_ready;
                if (out_ready) state_next = in_valid ? EXP : IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Datapath: operand capture, one exponent bit per EXP cycle, result capture
    always_ff @(posedge clk) begin
        if (rst) begin
            w_reg    <= '0;
            acc_reg  <= '0;
            step_reg <= '0;
            y_reg    <= '0;
        end else if (accept) begin
            w_reg    <= iso(x);
            acc_reg  <= COMP_ONE;
            step_reg <= 3'd5;
        end else if (state_reg == EXP) begin
            acc_reg <= acc_step;
            if (step_reg == 3'd0) begin
                y_reg <= inv_iso(acc_step);
            end else begin
                step_reg <= step_reg - 3'd1;
            end
        end
    end

endmodule

// File: tb/tb_sms32_20_inv_iter.sv
// Bench for sms32_20_inv_iter: directed steps, scoreboard queue of expected
// results, golden model computed directly in the GF(2^6) polynomial basis.
module tb_sms32_20_inv_iter;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [5:0] x;
    logic       out_valid;
    logic       out_ready;
    logic [5:0] y;
`ifdef SMS32_FWD_MODE_EN
    logic       mode;
`endif

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [5:0] xin;
        logic [5:0] yexp;
    } sb_t;
    sb_t sb[$];

    sms32_20_inv_iter dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .x         (x),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .y         (y)
`ifdef SMS32_FWD_MODE_EN
        ,
        .mode      (mode)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL timeout total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

    // GF(2^6) multiply modulo x^6+x^5+x^3+x^2+1
    function automatic logic [5:0] gmul(input logic [5:0] a, input logic [5:0] b);
        logic [6:0] aa;
        logic [5:0] r;
        aa = {1'b0, a};
        r  = '0;
        for (int i = 0; i < 6; i++) begin
            if (b[i]) r = r ^ aa[5:0];
            aa = aa << 1;
            if (aa[6]) aa = aa ^ 7'h6D;
        end
        return r;
    endfunction

    function automatic logic [5:0] gpow(input logic [5:0] a, input logic [5:0] e);
        logic [5:0] r;
        r = 6'd1;
        for (int i = 5; i >= 0; i--) begin
            r = gmul(r, r);
            if (e[i]) r = gmul(r, a);
        end
        return r;
    endfunction

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Called at a negedge where the DUT should be ready; acceptance at next posedge
    task automatic start(input logic [5:0] xv, input logic md);
        sb_t e;
        x        = xv;
        in_valid = 1'b1;
`ifdef SMS32_FWD_MODE_EN
        mode   = md;
        e.yexp = md ? gpow(xv, 6'd20) : gpow(xv, 6'd41);
`else
        e.yexp = gpow(xv, 6'd41);
`endif
        e.xin = xv;
        #1;
        check("accept_in_ready", in_ready, 1);
        sb.push_back(e);
    endtask

    // Walks T+1..T+7, checking busy flags then the popped result
    task automatic finish_one(input bit toggle, output logic [5:0] got);
        sb_t e;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            in_valid = 1'b0;
            if (toggle) x = 6'($urandom);
            #1;
            check("busy_in_ready", in_ready, 0);
            check("busy_out_valid", out_valid, 0);
        end
        @(negedge clk);
        #1;
        check("latency_out_valid", out_valid, 1);
        check("sb_nonempty", (sb.size() > 0), 1);
        got = y;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check("result_y", y, e.yexp);
            $display("xact x=%02h y=%02h exp=%02h", e.xin, y, e.yexp);
        end
    endtask

    initial begin
        logic [5:0] got;
        logic [5:0] got2;
        logic [5:0] held;
        bit         seen [64];

        rst = 1'b1; in_valid = 1'b0; x = '0; out_ready = 1'b1;
`ifdef SMS32_FWD_MODE_EN
        mode = 1'b0;
`endif
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("reset_in_ready", in_ready, 1);
        check("reset_out_valid", out_valid, 0);
        check("reset_y", y, 0);

        // Zero input and exact latency
        start(6'd0, 1'b0);
        finish_one(1'b0, got);
        check("zero_y", got, 0);

        // Every input, back-to-back; forward golden must recover x
        foreach (seen[i]) seen[i] = 1'b0;
        for (int i = 0; i < 64; i++) begin
            start(6'(i), 1'b0);
            finish_one(1'b0, got);
            check("fwd_roundtrip", gpow(got, 6'd20), 8'(i));
            check("y_distinct", seen[got], 0);
            seen[got] = 1'b1;
        end
        in_valid = 1'b0;
        @(negedge clk);
        #1;
        check("idle_in_ready", in_ready, 1);
        check("idle_out_valid", out_valid, 0);

        // Consumer stall in DONE, then accept during release
        out_ready = 1'b0;
        start(6'h2A, 1'b0);
        finish_one(1'b0, held);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            in_valid = 1'b1;
            x        = 6'h11;
            #1;
            check("stall_y", y, held);
            check("stall_out_valid", out_valid, 1);
            check("stall_in_ready", in_ready, 0);
        end
        @(negedge clk);
        out_ready = 1'b1;
        start(6'h07, 1'b0);
        finish_one(1'b0, got);

        // Reset at T+3 aborts the operation
        @(negedge clk);
        x = 6'h33; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("abort_in_ready", in_ready, 1);
        check("abort_out_valid", out_valid, 0);
        check("abort_y", y, 0);
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            #1;
            check("abort_no_out", out_valid, 0);
        end
        @(negedge clk);
        start(6'h15, 1'b0);
        finish_one(1'b0, got);

        // Reset wins over a simultaneous handshake
        @(negedge clk);
        x = 6'h09; in_valid = 1'b1; rst = 1'b1;
        @(negedge clk);
        rst = 1'b0; in_valid = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            #1;
            check("rst_prio_no_out", out_valid, 0);
            check("rst_prio_in_ready", in_ready, 1);
        end

        // Input toggling during EXP must not disturb the result
        start(6'h2B, 1'b0);
        finish_one(1'b1, got);
        start(6'h3C, 1'b0);
        finish_one(1'b1, got);

`ifdef SMS32_FWD_MODE_EN
        // Forward then inverse returns the original value
        for (int i = 0; i < 64; i++) begin
            start(6'(i), 1'b1);
            finish_one(1'b0, got);
            start(got, 1'b0);
            finish_one(1'b0, got2);
            check("mode_roundtrip", got2, 8'(i));
        end
`endif

        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sms32_20_inv_iter.md
SMS32_20_INV_ITER -- requirements
Module: sms32_20_inv_iter

Interface
REQ-001 The block SHALL have a single clock, and its reset SHALL be synchronous and active-high.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  synchronous active-high reset.
REQ-004 in_valid  input  1  x is valid this cycle.
REQ-005 in_ready  output  1  block can accept x this cycle.
REQ-006 x  input  6  GF(2^6) operand, polynomial-basis representation of the forward S-box output.
REQ-007 out_valid  output  1  y is valid; held until accepted.
REQ-008 out_ready  input  1  consumer accepts y this cycle.
REQ-009 y  output  6  result y = x^41 in the same representation; 41 = 20^-1 mod 63, so the block inverts the power-20 S-box.

Function
REQ-010 Transfer rules: an input is accepted on a cycle with in_valid && in_ready; an output is consumed on a cycle with out_valid && out_ready.
REQ-011 States: IDLE, EXP, DONE.
REQ-012 IDLE: in_ready=1 and out_valid=0; on acceptance, w=iso(x) is registered, acc is set to composite one (000001), step=5, and the FSM moves to EXP.
REQ-013 EXP: one exponent bit per cycle, MSB first, over e=101001b: acc <= acc^2, times w when e[step]=1; step decrements each cycle; after step 0 the FSM moves to DONE.
REQ-014 Square and multiply SHALL be computed in the composite field GF((2^3)^2), with GF(2^3) reduction polynomial t^3+t+1 and the same iso/inv_iso maps as the forward power-20 S-box.
REQ-015 DONE: y = inv_iso(acc) is registered on entry; out_valid=1; y is stable while out_valid=1 and out_ready=0.
REQ-016 Fixed latency: if acceptance occurs in cycle T, out_valid SHALL be first high in cycle T+7, independent of x.
REQ-017 DONE with out_ready=1: in_ready=1; with in_valid=1 a new x is accepted (back-to-back, next result at T+7); with in_valid=0 the FSM goes to IDLE.
REQ-018 in_ready SHALL be 0 in EXP, and in DONE when out_ready=0; in_valid is ignored when in_ready=0.
REQ-019 x=0 SHALL yield y=0; no special-casing is needed, since the exponentiation gives 0 for input 0.
REQ-020 Changes on x after acceptance SHALL NOT affect the in-flight result.

Reset
REQ-021 rst SHALL force: state=IDLE, out_valid=0, in_ready=1 (from the first cycle after reset), y=0, acc=0, w=0, step=0.
REQ-022 Reset asserted mid-EXP or in DONE SHALL abort the operation with no output.
REQ-023 Reset SHALL take priority over any simultaneous handshake.

Configuration
REQ-024 Macro SMS32_FWD_MODE_EN: when defined, the block SHALL add port mode (input, 1 bit), sampled at acceptance and registered.
REQ-025 With the macro, mode=0 SHALL select e=41 (inverse) and mode=1 SHALL select e=20=010100b (forward); latency is T+7 for both.
REQ-026 Without the macro, the mode port SHALL be absent and e=41 fixed.

Structure
REQ-027 Shared package sms32_gf_pkg SHALL hold: EXP_INV=41, EXP_FWD=20, EXP_W=6, the composite-one constant, and the FSM state enum.
REQ-028 The package SHALL also hold iso/inv_iso and GF(2^3) mul/square as functions.
REQ-029 One sub-module gf64_comp_mul (6-bit a, b -> 6-bit product, combinational) SHALL be instantiated twice: square (a=b=acc) and multiply (acc^2 * w).

Verification
REQ-030 Reset, then x=0 accepted at T -> out_valid first high at T+7 with y=0; in_ready=0 for T+1..T+6.
REQ-031 All 64 x sequentially -> forward power-20 golden model applied to y returns x for every x; all 64 y are distinct.
REQ-032 Hold out_ready=0 for 5 cycles in DONE -> y and out_valid stable; in_ready=0; then out_ready=1 with in_valid=1 -> new x accepted the same cycle.
REQ-033 Assert rst at T+3 of an operation -> out_valid never rises for it; in_ready=1 from the first cycle after reset; the next x=0x15 completes normally at acceptance+7.
REQ-034 With SMS32_FWD_MODE_EN: for all 64 x, mode=1 then mode=0 on its result -> original x returned.
REQ-035 Toggle x every cycle during EXP -> result equals x^41 of the value captured at acceptance.
